regfile_16bit: RTL



---
 rtl/regfile_16bit_pkg.sv | 20 ++
 rtl/regfile_16bit_regjistri.sv | 39 +++
 rtl/regfile_16bit.sv | 74 +++++++
 3 files changed

// File: rtl/regfile_16bit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_16bit_pkg
// Brief    : Shared widths, register count and address constants for the
//            16-bit CPU register file.
// Revision : 1.0
// ============================================================================
package regfile_16bit_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t ZERO_REG = 3'd0;

endpackage
`default_nettype wire

// File: rtl/regfile_16bit_regjistri.sv
`default_nettype none
// ============================================================================
// Module   : regjistri_16bit
// Brief    : Single register with synchronous active-high clear and load
//            enable; clear wins over load.
// Revision : 1.0
// ============================================================================
module regjistri_16bit #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_value_q;
    logic [DATA_W-1:0] w_value_d;

    always_comb begin
        w_value_d = r_value_q;
        if (i_load) begin
            w_value_d = i_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value_q <= '0;
        end else begin
            r_value_q <= w_value_d;
        end
    end

    assign o_q = r_value_q;

endmodule
`default_nettype wire

// File: rtl/regfile_16bit.sv
`default_nettype none
// ============================================================================
// Module   : regfile_16bit
// Brief    : 8 x 16-bit register file, two combinational read ports, one
//            synchronous write port, R0 hardwired to zero.
//            Optional macro REGFILE_BYPASS_EN forwards write data to a read
//            port addressing the register being written in the same cycle.
// Revision : 1.0
// ============================================================================
module regfile_16bit #(
    parameter int DATA_W = regfile_16bit_pkg::DATA_W,
    parameter int ADDR_W = regfile_16bit_pkg::ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] AdresaW,
    input  logic [DATA_W-1:0] HyrjaW,
    input  logic [ADDR_W-1:0] AdresaA,
    input  logic [ADDR_W-1:0] AdresaB,
    output logic [DATA_W-1:0] DaljaA,
    output logic [DATA_W-1:0] DaljaB
);

    import regfile_16bit_pkg::*;

    localparam int c_num_regs = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(ZERO_REG);

    logic [c_num_regs-1:0][DATA_W-1:0] w_regs;
    logic [DATA_W-1:0]                 w_dalja_a;
    logic [DATA_W-1:0]                 w_dalja_b;

    // R0 has no storage; it is a constant zero in the read mux.
    assign w_regs[0] = '0;

    genvar i;
    generate
        for (i = 1; i < c_num_regs; i++) begin : g_regs
            logic w_load;
            assign w_load = RegWrite && (AdresaW == ADDR_W'(i));

            regjistri_16bit #(
                .DATA_W (DATA_W)
            ) u_reg (
                .clk    (Clock),
                .rst    (Reset),
                .i_load (w_load),
                .i_d    (HyrjaW),
                .o_q    (w_regs[i])
            );
        end
    endgenerate

    always_comb begin
        w_dalja_a = w_regs[AdresaA];
        w_dalja_b = w_regs[AdresaB];
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && !Reset && (AdresaW != c_zero_addr)) begin
            if (AdresaW == AdresaA) begin
                w_dalja_a = HyrjaW;
            end
            if (AdresaW == AdresaB) begin
                w_dalja_b = HyrjaW;
            end
        end
`endif
    end

    assign DaljaA = w_dalja_a;
    assign DaljaB = w_dalja_b;

endmodule
`default_nettype wire
